// File: rtl/booth4_csa_iter.sv
// booth4_csa_iter
// Iterative radix-4 Booth multiplier front end. One Booth digit of the
// multiplier is recoded per cycle. Its partial product is folded into a
// carry-save register pair (row_a = sum row, row_b = carry row). The two
// rows are handed to a downstream carry-propagate adder. That adder's sum,
// taken mod 2^(2N), is the unsigned product x*y. Its carry-out is meaningless.

module booth4_csa_iter #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic [N-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   row_a,
    output logic [2*N-1:0]   row_b
);

    localparam int W  = 2 * N;        // row width
    localparam int D  = N / 2 + 1;    // number of Booth digits
    localparam int KW = $clog2(D + 1);
    localparam int YW = N + 3;        // {2 zero guard bits, y, implicit y[-1]}

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Radix-4 Booth recode of a bit triple {y[2k+1], y[2k], y[2k-1]}.
    // Returns {neg, two, one}: the digit is (neg ? -1 : +1) * (two ? 2 : one).
    function automatic logic [2:0] booth_recode(input logic [2:0] trip);
        logic [2:0] code;
        case (trip)
            3'b000, 3'b111: code = 3'b000;  //  0
            3'b001, 3'b010: code = 3'b001;  // +1
            3'b011:         code = 3'b010;  // +2
            3'b100:         code = 3'b110;  // -2
            3'b101, 3'b110: code = 3'b101;  // -1
            default:        code = 3'b000;
        endcase
        return code;
    endfunction

    // Bitwise majority, the carry function of a 3:2 compressor.
    function automatic logic [W-1:0] maj3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            in_ready_next_s;
    logic            out_valid_next_s;
    logic            accept_s;
    logic            last_digit_s;

    logic [KW-1:0]   k_r;
    logic [W-1:0]    x_sh_r;      // x << 2k, mod 2^W
    logic [YW-1:0]   y_sh_r;      // y window; [2:0] is the current triple
    logic [W-1:0]    row_a_r;
    logic [W-1:0]    row_b_r;

    logic [2:0]      digit_s;
    logic            neg_s;
    logic [W-1:0]    mag_s;
    logic [W-1:0]    pp_s;
    logic [W-1:0]    sum_s;
    logic [W-1:0]    carry_s;

    // An operand pair is taken only while idle and advertising ready.
    assign accept_s     = (state_r == IDLE) && in_valid && in_ready_r;
    assign last_digit_s = (k_r == KW'(D - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: accept -> D digit cycles -> hold until consumed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (last_digit_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Handshake flag values for the coming state, registered below.
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        case (state_next_s)
            IDLE: begin
                in_ready_next_s  = 1'b1;
                out_valid_next_s = 1'b0;
            end
            BUSY: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b0;
            end
            DONE: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b1;
            end
            default: begin
                in_ready_next_s  = 1'b0;
                out_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered handshake flags. Reset holds in_ready low until the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Current digit's partial product and its 3:2 compression with the rows.
    // A negative digit contributes ~m. Its +1 enters through the carry
    // row's free bit 0, which the left shift of the carries leaves open.
    always_comb begin
        digit_s = booth_recode(y_sh_r[2:0]);
        neg_s   = digit_s[2];
        if (digit_s[1]) begin
            mag_s = {x_sh_r[W-2:0], 1'b0};
        end else if (digit_s[0]) begin
            mag_s = x_sh_r;
        end else begin
            mag_s = {W{1'b0}};
        end
        if (neg_s) begin
            pp_s = ~mag_s;
        end else begin
            pp_s = mag_s;
        end
        sum_s   = row_a_r ^ row_b_r ^ pp_s;
        carry_s = maj3(row_a_r, row_b_r, pp_s);
        carry_s = {carry_s[W-2:0], neg_s};
    end

    // Datapath registers: load on accept, step one digit per busy cycle,
    // and hold everything while done or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_r     <= {KW{1'b0}};
            x_sh_r  <= {W{1'b0}};
            y_sh_r  <= {YW{1'b0}};
            row_a_r <= {W{1'b0}};
            row_b_r <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        k_r     <= {KW{1'b0}};
                        x_sh_r  <= {{N{1'b0}}, x};
                        y_sh_r  <= {2'b00, y, 1'b0};
                        row_a_r <= {W{1'b0}};
                        row_b_r <= {W{1'b0}};
                    end else begin
                        k_r     <= k_r;
                        x_sh_r  <= x_sh_r;
                        y_sh_r  <= y_sh_r;
                        row_a_r <= row_a_r;
                        row_b_r <= row_b_r;
                    end
                end
                BUSY: begin
                    k_r     <= k_r + KW'(1'b1);
                    x_sh_r  <= {x_sh_r[W-3:0], 2'b00};
                    y_sh_r  <= {2'b00, y_sh_r[YW-1:2]};
                    row_a_r <= sum_s;
                    row_b_r <= carry_s;
                end
                default: begin
                    k_r     <= k_r;
                    x_sh_r  <= x_sh_r;
                    y_sh_r  <= y_sh_r;
                    row_a_r <= row_a_r;
                    row_b_r <= row_b_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign row_a     = row_a_r;
    assign row_b     = row_b_r;

endmodule

// File: doc/booth4_csa_iter.md
# booth4_csa_iter

Iterative radix-4 Booth multiplier front end for the N×N unsigned multiplier.
- Accepts one operand pair per transaction.
- Recodes the multiplier into radix-4 Booth digits and accumulates one partial product per cycle in a carry-save register pair.
- Presents the two 2N-bit rows to the downstream 2N-bit prefix carry-propagate adder (MG_CPA).
- The adder's sum is the product; its carry-out carries no meaning and is ignored.

## Interface
Parameters:
- N, 4, operand width; must be even and ≥ 4; row width W = 2N; digit count D = N/2 + 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- x  input  N  multiplicand, unsigned.
- y  input  N  multiplier, unsigned.
- out_valid  output  1  row_a/row_b hold a completed carry-save result.
- out_ready  input  1  downstream consumes the result.
- row_a  output  2N  carry-save sum row; drives CPA input a.
- row_b  output  2N  carry-save carry row; drives CPA input b.

## Operation
- States: IDLE, BUSY, DONE. All registers are reset to zero or IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch x and y, clear row_a/row_b and the digit counter k, then go to BUSY.
- BUSY: one digit per cycle, k = 0..D-1.
  - Digit k is taken from bits (y[2k+1], y[2k], y[2k-1]).
  - y[-1] = 0, and y bits at positions ≥ N read as 0.
  - Recoding: 000/111 → 0, 001/010 → +1, 011 → +2, 100 → −2, 101/110 → −1.
  - Magnitude m = |d|·x, which is 0, x, or x<<1. It is zero-extended to W bits and shifted left by 2k, with the result taken mod 2^W.
  - Partial product pp:
    - If d ≥ 0, pp = m.
    - If d < 0, pp = ~m over all W bits, with neg = 1.
  - 3:2 compression over row_a, row_b, pp:
    - row_a' = a ^ b ^ pp.
    - row_b' = ((a&b | a&pp | b&pp) << 1) mod 2^W, with bit 0 = neg.
    - The neg bit supplies the two's-complement +1 at weight 2^0.
  - After k = D-1 is processed, go to DONE.
- DONE:
  - out_valid = 1; row_a and row_b are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0 throughout DONE; transactions do not overlap.
- Arithmetic invariant in DONE: (row_a + row_b) mod 2^W = x·y.
  - The product is exact because x·y < 2^W.
  - The raw sum row_a + row_b may exceed 2^W; the downstream carry-out is discarded.
- Reset mid-operation: rst_n low at any time immediately forces IDLE, with out_valid = 0, in_ready = 0 while rst_n is low, and rows = 0. The partial transaction is dropped without output.
- An in_valid pulse that arrives while not in IDLE is ignored. The upstream keeps in_valid and the operands stable until in_ready.
- out_ready while not in DONE has no effect.

## Timing
- Reset values:
  - in_ready = 0 during reset, then 1 from the first cycle after release.
  - out_valid = 0.
  - row_a = row_b = 0.
- Acceptance at edge E0. BUSY edges are E1..ED. out_valid rises after edge ED, i.e. D cycles after acceptance (3 cycles for N = 4).
- Output handshake completes on the edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- Minimum initiation interval is D + 2 cycles: accept, D BUSY cycles, then the DONE handshake.
- Outputs are registered only; there is no combinational path from in_valid or out_ready to any output other than through state.

## Test plan
- x=0, y=0:
  - Required: out_valid 3 cycles after acceptance.
  - Required: row_a + row_b mod 256 = 0.
- x=15, y=15, digits −1, 0, +1:
  - Required: row_a + row_b mod 256 = 225.
  - Required: row_b[0] = 1 after the first BUSY cycle.
- x=7, y=9, digits +1, −2, +1:
  - Required: sum mod 256 = 63.
  - Required: CPA output sum = 63, and cout is ignored.
- Exhaustive 256 pairs with out_ready held at 1:
  - Required: every result equals x·y.
  - Required: in_ready pattern repeats 1, 0, 0, 0, 0.
- Backpressure: out_ready held low for 5 cycles after out_valid.
  - Required: rows and out_valid held stable throughout.
  - Required: in_ready = 0 throughout.
  - Required: completion occurs on the cycle out_ready rises.
- Reset asserted in the second BUSY cycle:
  - Required: out_valid = 0 and rows = 0 immediately.
  - Required: in_ready = 1 after release.
  - Required: next transaction x=3, y=5 yields 15.
